exe_hazard_ctrl: RTL

- Controls the execute-stage operand path of the 5-stage core.
- Keeps a small scoreboard of destination registers in flight in EX, MEM and WB.
- Produces registered forwarding selects for ALU operands A and B, which override the read_data_1/read_data_2 source when the operand selector picks the register path.
- Detects load-use hazards, stalls IF/ID for one cycle, injects an EX bubble, and counts stall cycles for performance monitoring.

---
 rtl/exe_hazard_ctrl_if.sv | 25 ++
 rtl/exe_hazard_ctrl.sv | 47 ++++
 2 files changed

// File: rtl/exe_hazard_ctrl_if.sv
// exe_hazard_ctrl_if: ID-stage operand info in, EX forwarding selects and stall controls out
interface exe_hazard_ctrl_if #(parameter int REG_ADDR_W = 5, parameter int CNT_W = 32);
   logic                  id_valid;
   logic [REG_ADDR_W-1:0] id_rs1;
   logic [REG_ADDR_W-1:0] id_rs2;
   logic                  id_use_rs1;
   logic                  id_use_rs2;
   logic [REG_ADDR_W-1:0] id_rd;
   logic                  id_we;
   logic                  id_is_load;
   logic                  mem_stall;
   logic [1:0]            fwd_a_sel;
   logic [1:0]            fwd_b_sel;
   logic                  stall_id;
   logic                  bubble_ex;
   logic [CNT_W-1:0]      stall_cnt;
   modport master (
      output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_we, id_is_load, mem_stall,
      input  fwd_a_sel, fwd_b_sel, stall_id, bubble_ex, stall_cnt
   );
   modport slave (
      input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_we, id_is_load, mem_stall,
      output fwd_a_sel, fwd_b_sel, stall_id, bubble_ex, stall_cnt
   );
endinterface

// File: rtl/exe_hazard_ctrl.sv
// exe_hazard_ctrl: EX-stage forwarding selects, load-use stall/bubble and saturating stall counter
module exe_hazard_ctrl #(
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 32
) (
   input logic clk,
   input logic rst,
   exe_hazard_ctrl_if.slave h
);
   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] rd;
      logic                  we;
      logic                  is_load;
   } entry_t;
   entry_t ex, mem, wb;
   logic hazard;
   logic unused_sb;
   function automatic logic [1:0] fwd_sel(input logic use_rs, input logic [REG_ADDR_W-1:0] rs);
      fwd_sel = !use_rs || rs == '0 ? 2'd0 :
                ex.valid && ex.we && ex.rd == rs ? 2'd1 :
                mem.valid && mem.we && mem.rd == rs ? 2'd2 : 2'd0;
   endfunction
   assign hazard = h.id_valid && ex.valid && ex.is_load && ex.we && ex.rd != '0 &&
                   ((h.id_use_rs1 && h.id_rs1 == ex.rd) || (h.id_use_rs2 && h.id_rs2 == ex.rd));
   assign h.stall_id  = hazard || h.mem_stall;
   assign h.bubble_ex = hazard && !h.mem_stall;
   // WB is kept for visibility only; the write-first regfile means nothing there is forwarded
   assign unused_sb = ^{wb, mem.is_load};
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         ex          <= '0;
         mem         <= '0;
         wb          <= '0;
         h.fwd_a_sel <= '0;
         h.fwd_b_sel <= '0;
         h.stall_cnt <= '0;
      end else if (!h.mem_stall) begin
         wb          <= mem;
         mem         <= ex;
         ex          <= hazard ? '0 : {h.id_valid, h.id_rd, h.id_we && h.id_valid, h.id_is_load};
         h.fwd_a_sel <= hazard ? 2'd0 : fwd_sel(h.id_use_rs1, h.id_rs1);
         h.fwd_b_sel <= hazard ? 2'd0 : fwd_sel(h.id_use_rs2, h.id_rs2);
         if (hazard && h.stall_cnt != {CNT_W{1'b1}})
            h.stall_cnt <= h.stall_cnt + CNT_W'(1);
      end
endmodule
